// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared types and constants for the sdram_ctl port arbiter
// Purpose: FSM state encoding, sdram_ctl app_wr command encoding, default data
//          width, and the candidate-order helper used by the winner selector.
// Ports:   none (package).
package sdram_pkg;

  localparam int DQ_WIDTH_DEF = 16;

  // sdram_ctl app_wr encoding
  localparam logic WR_CMD = 1'b0;
  localparam logic RD_CMD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_STRB,
    ST_STREAM,
    ST_GAP
  } arb_state_t;

  // k-th port to consider: fixed order starts at 0, round-robin starts just
  // after the last granted port and wraps.
  function automatic int pick_cand(input int ptr, input int k, input int n, input logic fixed);
    return fixed ? k : (ptr + 1 + k) % n;
  endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// rtl/sdram_rr_pick.sv - combinational round-robin / fixed-priority winner selector
// Purpose: picks one requester out of N_PORTS.
// Ports:   req   - request vector
//          ptr   - last granted index (round-robin only)
//          fixed - 1 = lowest index wins, 0 = round-robin after ptr
//          gnt   - one-hot winner, idx - winner index, any - some request present
module sdram_rr_pick
  import sdram_pkg::*;
#(
  parameter int N_PORTS = 2
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [1:0]         ptr,
  input  logic               fixed,
  output logic [N_PORTS-1:0] gnt,
  output logic [1:0]         idx,
  output logic               any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      for (int j = 0; j < N_PORTS; j++) begin
        if (!any && req[j] && (j == pick_cand(int'(ptr), k, N_PORTS, fixed))) begin
          gnt[j] = 1'b1;
          idx    = 2'(j);
          any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - shares one sdram_ctl application port between N_PORTS requesters
// Purpose: grants one burst at a time, holds the command fields stable for the
//          whole transfer, routes data strobes to the granted port and reports
//          completion or watchdog abort per port.
// Ports:   clk, rst (sync, active high)
//          port_req/wr/len/addr/wr_data - per-port request side (flattened vectors)
//          port_ack/done/err            - one-cycle per-port pulses
//          port_wr_next/port_rd_valid   - strobes routed to the granted port only
//          rd_data - read data broadcast, busy - not idle, grant_id - current/last winner
//          app_*   - sdram_ctl application interface
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int N_PORTS    = 2,
  parameter int DQ_WIDTH   = DQ_WIDTH_DEF,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 4095
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PORTS-1:0]           port_req,
  input  logic [N_PORTS-1:0]           port_wr,
  input  logic [8*N_PORTS-1:0]         port_len,
  input  logic [32*N_PORTS-1:0]        port_addr,
  input  logic [DQ_WIDTH*N_PORTS-1:0]  port_wr_data,
  output logic [N_PORTS-1:0]           port_ack,
  output logic [N_PORTS-1:0]           port_wr_next,
  output logic [N_PORTS-1:0]           port_rd_valid,
  output logic [N_PORTS-1:0]           port_done,
  output logic [N_PORTS-1:0]           port_err,
  output logic [DQ_WIDTH-1:0]          rd_data,
  output logic                         busy,
  output logic [1:0]                   grant_id,
  output logic                         app_req,
  input  logic                         app_req_ack,
  output logic                         app_wr,
  output logic [7:0]                   app_req_len,
  output logic [31:0]                  app_req_addr,
  output logic [DQ_WIDTH-1:0]          app_wr_data,
  input  logic                         app_wr_next_req,
  input  logic [DQ_WIDTH-1:0]          app_rd_data,
  input  logic                         app_rd_ready
);

  // TIMEOUT = 0 disables the watchdog, so TO_LAST is never compared then.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  arb_state_t           state, state_d;
  logic [15:0]          wd_cnt;
  logic [1:0]           rr_ptr;
  logic [N_PORTS-1:0]   win_oh, cur_oh;
  logic [1:0]           win_idx;
  logic                 win_any;
  logic                 sel_wr;
  logic [7:0]           sel_len;
  logic [31:0]          sel_addr;
  logic                 strobe, timeout;
  logic                 do_grant, drop_req, do_done, do_err, do_gap;

  sdram_rr_pick #(.N_PORTS(N_PORTS)) u_pick (
    .req   (port_req),
    .ptr   (rr_ptr),
    .fixed (FIXED_PRIO != 0),
    .gnt   (win_oh),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Command fields of the winner, latched at grant time.
  always_comb begin
    sel_wr   = 1'b0;
    sel_len  = '0;
    sel_addr = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (win_idx == 2'(i)) begin
        sel_wr   = port_wr[i];
        sel_len  = port_len[i*8 +: 8];
        sel_addr = port_addr[i*32 +: 32];
      end
    end
  end

  // Strobe routing and write-data mux follow the registered grant with no added latency.
  always_comb begin
    cur_oh        = '0;
    port_wr_next  = '0;
    port_rd_valid = '0;
    app_wr_data   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_id == 2'(i)) begin
        cur_oh[i]   = 1'b1;
        app_wr_data = port_wr_data[i*DQ_WIDTH +: DQ_WIDTH];
        if (state == ST_WAIT_STRB || state == ST_STREAM) begin
          port_wr_next[i]  = app_wr_next_req;
          port_rd_valid[i] = app_rd_ready;
        end
      end
    end
  end

  assign rd_data = app_rd_data;
  assign busy    = (state != ST_IDLE);
  assign strobe  = (app_wr == RD_CMD) ? app_rd_ready : app_wr_next_req;
  assign timeout = (TIMEOUT != 0) && (wd_cnt == TO_LAST);

  always_comb begin
    state_d  = state;
    do_grant = 1'b0;
    drop_req = 1'b0;
    do_done  = 1'b0;
    do_err   = 1'b0;
    do_gap   = 1'b0;
    case (state)
      ST_IDLE: if (win_any) begin
        do_grant = 1'b1;
        state_d  = ST_REQ;
      end
      ST_REQ: if (app_req_ack) begin
        drop_req = 1'b1;
        state_d  = ST_WAIT_STRB;
      end else if (timeout) begin
        drop_req = 1'b1;
        do_err   = 1'b1;
        state_d  = ST_GAP;
      end
      ST_WAIT_STRB: if (strobe) begin
        state_d = ST_STREAM;
      end else if (timeout) begin
        do_err  = 1'b1;
        state_d = ST_GAP;
      end
      ST_STREAM: if (!strobe) begin
        do_done = 1'b1;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        do_gap  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Watchdog restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      wd_cnt <= '0;
    end else begin
      state  <= state_d;
      wd_cnt <= (state_d != state) ? 16'd0 : wd_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      port_ack     <= '0;
      port_done    <= '0;
      port_err     <= '0;
      grant_id     <= '0;
      rr_ptr       <= '0;
      app_req      <= 1'b0;
      app_wr       <= 1'b0;
      app_req_len  <= '0;
      app_req_addr <= '0;
    end else begin
      port_ack  <= '0;
      port_done <= '0;
      port_err  <= '0;
      if (do_grant) begin
        port_ack     <= win_oh;
        grant_id     <= win_idx;
        app_req      <= 1'b1;
        app_wr       <= sel_wr;
        app_req_len  <= sel_len;
        app_req_addr <= sel_addr;
      end
      if (drop_req) app_req   <= 1'b0;
      if (do_done)  port_done <= cur_oh;
      if (do_err)   port_err  <= cur_oh;
      if (do_gap)   rr_ptr    <= grant_id;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed self-checking bench for sdram_arbiter
module tb_sdram_arbiter;
  import sdram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  port_req, port_wr;
  logic [15:0] port_len;
  logic [63:0] port_addr;
  logic [31:0] port_wr_data;

  logic [1:0]  port_ack, port_wr_next, port_rd_valid, port_done, port_err, grant_id;
  logic [15:0] rd_data, app_wr_data;
  logic        busy;
  logic [7:0]  app_req_len;
  logic [31:0] app_req_addr;

  logic [1:0]  port_ack_b, port_wr_next_b, port_rd_valid_b, port_done_b, port_err_b, grant_id_b;
  logic [15:0] rd_data_b, app_wr_data_b;
  logic        busy_b;
  logic [7:0]  app_req_len_b;
  logic [31:0] app_req_addr_b;

  // controller-side signals: index 0 = round-robin DUT, 1 = fixed-priority DUT
  logic        app_req_v[2], app_wr_v[2], ack_v[2], wnext_v[2], rrdy_v[2];
  logic [15:0] rdata_v[2];
  bit          ack_en[2];
  int          beats[2];
  logic [15:0] rd_pat;

  int checks = 0, errors = 0;

  sdram_arbiter #(.N_PORTS(2), .DQ_WIDTH(16), .FIXED_PRIO(0), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .port_req(port_req), .port_wr(port_wr), .port_len(port_len),
    .port_addr(port_addr), .port_wr_data(port_wr_data), .port_ack(port_ack),
    .port_wr_next(port_wr_next), .port_rd_valid(port_rd_valid), .port_done(port_done),
    .port_err(port_err), .rd_data(rd_data), .busy(busy), .grant_id(grant_id),
    .app_req(app_req_v[0]), .app_req_ack(ack_v[0]), .app_wr(app_wr_v[0]),
    .app_req_len(app_req_len), .app_req_addr(app_req_addr), .app_wr_data(app_wr_data),
    .app_wr_next_req(wnext_v[0]), .app_rd_data(rdata_v[0]), .app_rd_ready(rrdy_v[0]));

  sdram_arbiter #(.N_PORTS(2), .DQ_WIDTH(16), .FIXED_PRIO(1), .TIMEOUT(16)) dut_fp (
    .clk(clk), .rst(rst), .port_req(port_req), .port_wr(port_wr), .port_len(port_len),
    .port_addr(port_addr), .port_wr_data(port_wr_data), .port_ack(port_ack_b),
    .port_wr_next(port_wr_next_b), .port_rd_valid(port_rd_valid_b), .port_done(port_done_b),
    .port_err(port_err_b), .rd_data(rd_data_b), .busy(busy_b), .grant_id(grant_id_b),
    .app_req(app_req_v[1]), .app_req_ack(ack_v[1]), .app_wr(app_wr_v[1]),
    .app_req_len(app_req_len_b), .app_req_addr(app_req_addr_b), .app_wr_data(app_wr_data_b),
    .app_wr_next_req(wnext_v[1]), .app_rd_data(rdata_v[1]), .app_rd_ready(rrdy_v[1]));

  // sdram_ctl stand-in: ack one cycle, one idle cycle, then beats[k] strobe cycles.
  task automatic ctl_model(input int k);
    int st = 0;
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        st = 0; ack_v[k] = 0; wnext_v[k] = 0; rrdy_v[k] = 0; rdata_v[k] = '0;
      end else begin
        case (st)
          0: if (app_req_v[k] && ack_en[k]) begin ack_v[k] = 1; st = 1; end
          1: begin ack_v[k] = 0; cnt = 0; st = 2; end
          2: begin
            if (app_wr_v[k] == RD_CMD) begin rrdy_v[k] = 1; rdata_v[k] = rd_pat; end
            else wnext_v[k] = 1;
            cnt++;
            if (cnt >= beats[k]) st = 3;
          end
          default: begin wnext_v[k] = 0; rrdy_v[k] = 0; rdata_v[k] = '0; st = 0; end
        endcase
      end
    end
  endtask

  int ack_cnt[2], ack_first[2], done_cnt[2], err_cnt[2], wnext_cnt[2], rvalid_cnt[2];
  int mirror_bad, addr_bad, len_bad, wdata_bad, rdata_bad, appreq_cyc, multi_ack, idle_to;
  int gseq[$], gseq_b[$];

  // Samples ncyc cycles after the driving negedge; cycle 0 is the first grant cycle.
  task automatic measure(input int ncyc, input bit hold, input int exp_port,
                         input logic [31:0] exp_addr, input logic [7:0] exp_len,
                         input logic [15:0] exp_wd, input int chg_cyc);
    for (int p = 0; p < 2; p++) begin
      ack_cnt[p] = 0; ack_first[p] = -1; done_cnt[p] = 0; err_cnt[p] = 0;
      wnext_cnt[p] = 0; rvalid_cnt[p] = 0;
    end
    mirror_bad = 0; addr_bad = 0; len_bad = 0; wdata_bad = 0; rdata_bad = 0;
    appreq_cyc = 0; multi_ack = 0;
    gseq.delete(); gseq_b.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if ($countones(port_ack) > 1) multi_ack++;
      if (app_req_v[0]) appreq_cyc++;
      for (int p = 0; p < 2; p++) begin
        if (port_ack[p]) begin
          if (ack_cnt[p] == 0) ack_first[p] = c;
          ack_cnt[p]++;
          gseq.push_back(p);
          if (!hold) port_req[p] = 1'b0;
        end
        if (port_ack_b[p]) gseq_b.push_back(p);
        if (port_done[p]) done_cnt[p]++;
        if (port_err[p]) err_cnt[p]++;
        if (port_wr_next[p]) wnext_cnt[p]++;
        if (port_rd_valid[p]) begin
          rvalid_cnt[p]++;
          if (rd_data !== rd_pat) rdata_bad++;
        end
      end
      if (exp_port >= 0) begin
        if (port_wr_next !== ({1'b0, wnext_v[0]} << exp_port) ||
            port_rd_valid !== ({1'b0, rrdy_v[0]} << exp_port)) mirror_bad++;
        if (busy && app_req_addr !== exp_addr) addr_bad++;
        if (busy && app_req_len !== exp_len) len_bad++;
        if (busy && app_wr_data !== exp_wd) wdata_bad++;
      end
      if (c == chg_cyc) port_len[7:0] = 8'hEE;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || busy_b) && n < 100) begin @(posedge clk); #1; n++; end
    if (busy || busy_b) idle_to++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; port_req = 0; port_wr = 0; port_len = 0; port_addr = 0; port_wr_data = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({port_ack, port_wr_next, port_rd_valid, port_done, port_err} !== 10'd0) begin
      errors++; $display("FAIL reset_port_outputs: got %b expected 0", {port_ack, port_wr_next, port_rd_valid, port_done, port_err}); end
    checks++; if (busy !== 1'b0 || grant_id !== 2'd0) begin
      errors++; $display("FAIL reset_busy_grant: got busy=%b grant=%0d expected 0/0", busy, grant_id); end
    checks++; if (app_req_v[0] !== 1'b0 || app_wr_v[0] !== 1'b0) begin
      errors++; $display("FAIL reset_app_req_wr: got %b%b expected 00", app_req_v[0], app_wr_v[0]); end
    checks++; if (app_req_len !== 8'd0 || app_req_addr !== 32'd0) begin
      errors++; $display("FAIL reset_len_addr: got %h/%h expected 0/0", app_req_len, app_req_addr); end
    checks++; if (app_wr_data !== 16'd0 || rd_data !== 16'd0) begin
      errors++; $display("FAIL reset_data: got %h/%h expected 0/0", app_wr_data, rd_data); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    beats[0] = 8; port_wr[0] = WR_CMD; port_len[7:0] = 8'd7; port_addr[31:0] = 32'h100;
    port_wr_data[15:0] = 16'h1234; port_req[0] = 1;
    measure(30, 0, 0, 32'h100, 8'd7, 16'h1234, 5);
    checks++; if (ack_first[0] !== 0) begin errors++; $display("FAIL wr_ack_latency: got %0d expected 0", ack_first[0]); end
    checks++; if (ack_cnt[0] !== 1 || ack_cnt[1] !== 0) begin errors++; $display("FAIL wr_ack_count: got %0d/%0d expected 1/0", ack_cnt[0], ack_cnt[1]); end
    checks++; if (appreq_cyc !== 1) begin errors++; $display("FAIL wr_app_req_cycles: got %0d expected 1", appreq_cyc); end
    checks++; if (wnext_cnt[0] !== 8 || wnext_cnt[1] !== 0) begin errors++; $display("FAIL wr_next_beats: got %0d/%0d expected 8/0", wnext_cnt[0], wnext_cnt[1]); end
    checks++; if (mirror_bad !== 0) begin errors++; $display("FAIL wr_strobe_mirror: got %0d bad cycles expected 0", mirror_bad); end
    checks++; if (done_cnt[0] !== 1 || done_cnt[1] !== 0) begin errors++; $display("FAIL wr_done: got %0d/%0d expected 1/0", done_cnt[0], done_cnt[1]); end
    checks++; if (addr_bad !== 0) begin errors++; $display("FAIL wr_addr_stable: got %0d bad cycles expected 0", addr_bad); end
    checks++; if (len_bad !== 0) begin errors++; $display("FAIL wr_len_stable: got %0d bad cycles expected 0", len_bad); end
    checks++; if (wdata_bad !== 0) begin errors++; $display("FAIL wr_data_mux: got %0d bad cycles expected 0", wdata_bad); end
    wait_idle();
    port_len[7:0] = 8'd7;
  endtask

  task automatic test_read_port1();
    @(negedge clk);
    beats[0] = 4; rd_pat = 16'hA5A5; port_wr[1] = RD_CMD; port_len[15:8] = 8'd3;
    port_addr[63:32] = 32'h200; port_wr_data[31:16] = 16'h5A5A; port_req[1] = 1;
    measure(20, 0, 1, 32'h200, 8'd3, 16'h5A5A, -1);
    checks++; if (ack_first[1] !== 0 || ack_cnt[0] !== 0) begin errors++; $display("FAIL rd_ack: got first=%0d ack0=%0d expected 0/0", ack_first[1], ack_cnt[0]); end
    checks++; if (rvalid_cnt[1] !== 4 || rvalid_cnt[0] !== 0) begin errors++; $display("FAIL rd_valid_beats: got %0d/%0d expected 4/0", rvalid_cnt[1], rvalid_cnt[0]); end
    checks++; if (rdata_bad !== 0) begin errors++; $display("FAIL rd_data: got %0d bad beats expected 0", rdata_bad); end
    checks++; if (mirror_bad !== 0 || addr_bad !== 0) begin errors++; $display("FAIL rd_route_addr: got %0d/%0d expected 0/0", mirror_bad, addr_bad); end
    checks++; if (done_cnt[1] !== 1 || done_cnt[0] !== 0) begin errors++; $display("FAIL rd_done: got %0d/%0d expected 1/0", done_cnt[1], done_cnt[0]); end
    checks++; if (grant_id !== 2'd1 || app_wr_v[0] !== RD_CMD) begin errors++; $display("FAIL rd_grant_cmd: got grant=%0d wr=%b expected 1/1", grant_id, app_wr_v[0]); end
    wait_idle();
  endtask

  task automatic test_rr_alternate();
    int exp_rr[4];
    exp_rr = '{0, 1, 0, 1};
    @(negedge clk);
    beats[0] = 2; port_wr = 2'b00; port_req = 2'b11;
    measure(30, 1, -1, 32'h0, 8'h0, 16'h0, -1);
    port_req = 2'b00;
    checks++; if (gseq.size() < 4 || gseq_b.size() < 4) begin
      errors++; $display("FAIL rr_grant_count: got %0d/%0d expected >=4", gseq.size(), gseq_b.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (gseq[i] !== exp_rr[i]) begin errors++; $display("FAIL rr_grant_%0d: got %0d expected %0d", i, gseq[i], exp_rr[i]); end
        checks++; if (gseq_b[i] !== 0) begin errors++; $display("FAIL fixed_grant_%0d: got %0d expected 0", i, gseq_b[i]); end
      end
    end
    checks++; if (multi_ack !== 0) begin errors++; $display("FAIL rr_single_ack: got %0d multi-ack cycles expected 0", multi_ack); end
    wait_idle();
  endtask

  task automatic test_timeout();
    int req_cnt = 0, err_c = -1, err0 = 0, err1 = 0, ack1_c = -1, done0 = 0, done1 = 0;
    @(negedge clk);
    beats[0] = 2; ack_en[0] = 0; port_wr = 2'b00; port_req = 2'b01;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        checks++; if (port_ack !== 2'b01) begin errors++; $display("FAIL to_first_ack: got %b expected 01", port_ack); end
        port_req = 2'b10;
      end
      if (app_req_v[0] && grant_id == 2'd0) req_cnt++;
      if (port_err[0]) begin if (err_c < 0) err_c = c; err0++; ack_en[0] = 1; end
      if (port_err[1]) err1++;
      if (port_ack[1] && ack1_c < 0) begin ack1_c = c; port_req[1] = 0; end
      if (port_done[0]) done0++;
      if (port_done[1]) done1++;
    end
    ack_en[0] = 1;
    checks++; if (req_cnt !== 16) begin errors++; $display("FAIL to_app_req_cycles: got %0d expected 16", req_cnt); end
    checks++; if (err_c !== 16) begin errors++; $display("FAIL to_err_cycle: got %0d expected 16", err_c); end
    checks++; if (err0 !== 1 || err1 !== 0) begin errors++; $display("FAIL to_err_count: got %0d/%0d expected 1/0", err0, err1); end
    checks++; if (ack1_c !== 18) begin errors++; $display("FAIL to_next_grant: got %0d expected 18", ack1_c); end
    checks++; if (done1 !== 1 || done0 !== 0) begin errors++; $display("FAIL to_done: got %0d/%0d expected 1/0", done1, done0); end
    wait_idle();
  endtask

  task automatic test_reset_mid_stream();
    bit seen = 0;
    int late_pulse = 0;
    int exp_seq[2];
    exp_seq = '{1, 0};
    @(negedge clk);
    beats[0] = 8; port_wr = 2'b00; port_req = 2'b01;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (port_ack[0]) port_req[0] = 0;
      if (port_wr_next[0]) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_reach_stream: got 0 expected 1"); end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    checks++; if ({port_ack, port_wr_next, port_rd_valid, port_done, port_err, grant_id} !== 12'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_outputs: got %b busy=%b expected 0", {port_ack, port_wr_next, port_rd_valid, port_done, port_err, grant_id}, busy); end
    checks++; if ({app_req_v[0], app_wr_v[0], app_req_len, app_req_addr} !== 42'd0) begin
      errors++; $display("FAIL rst_app_fields: got %h expected 0", {app_req_v[0], app_wr_v[0], app_req_len, app_req_addr}); end
    @(negedge clk); rst = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (port_done !== 2'b00 || port_err !== 2'b00) late_pulse++;
    end
    checks++; if (late_pulse !== 0) begin errors++; $display("FAIL rst_no_done: got %0d pulse cycles expected 0", late_pulse); end
    @(negedge clk);
    beats[0] = 2; port_req = 2'b11;
    measure(20, 0, -1, 32'h0, 8'h0, 16'h0, -1);
    checks++; if (gseq.size() !== 2) begin errors++; $display("FAIL rst_regrant_count: got %0d expected 2", gseq.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (gseq[i] !== exp_seq[i]) begin errors++; $display("FAIL rst_regrant_%0d: got %0d expected %0d", i, gseq[i], exp_seq[i]); end
      end
    end
    checks++; if (done_cnt[0] !== 1 || done_cnt[1] !== 1) begin errors++; $display("FAIL rst_regrant_done: got %0d/%0d expected 1/1", done_cnt[0], done_cnt[1]); end
    wait_idle();
    checks++; if (idle_to !== 0) begin errors++; $display("FAIL idle_wait: got %0d expired waits expected 0", idle_to); end
  endtask

  initial begin
    rst = 1; idle_to = 0; rd_pat = 16'h0;
    ack_en = '{1, 1}; beats = '{2, 2};
    for (int k = 0; k < 2; k++) begin
      ack_v[k] = 0; wnext_v[k] = 0; rrdy_v[k] = 0; rdata_v[k] = '0;
    end
    fork
      ctl_model(0);
      ctl_model(1);
    join_none
    test_reset();
    test_single_write();
    test_read_port1();
    test_rr_alternate();
    test_timeout();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
